// File: rtl/usb4_clk_pkg.sv
// Shared speed codes and controller state encoding for the clock-speed sequencer.
package usb4_clk_pkg;

  localparam logic [1:0] SPEED_0    = 2'b00;
  localparam logic [1:0] SPEED_1    = 2'b01;
  localparam logic [1:0] SPEED_2    = 2'b10;
  localparam logic [1:0] SPEED_RSVD = 2'b11;

  typedef enum logic [2:0] {
    ST_APPLY,
    ST_SETTLE,
    ST_RELEASE,
    ST_IDLE,
    ST_DRAIN,
    ST_GATE
  } ctrl_state_t;

  function automatic logic speed_is_rsvd(input logic [1:0] code);
    return code == SPEED_RSVD;
  endfunction

endpackage

// File: rtl/clk_speed_timer.sv
// Loadable down-counter that holds at zero; zero flag marks the last cycle of a state.
module clk_speed_timer #(
  parameter int unsigned    TW      = 8,
  parameter logic [TW-1:0] RST_VAL = '0
) (
  input  logic          local_clk,
  input  logic          rst,
  input  logic          load,
  input  logic [TW-1:0] load_val,
  output logic          zero
);

  logic [TW-1:0] count;

  // Load on state entry, otherwise count down and hold at zero.
  always_ff @(posedge local_clk or negedge rst) begin
    if (!rst) begin
      count <= RST_VAL;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - TW'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/clk_speed_ctrl.sv
// Sequences generation-speed changes: drain, gate clocks, apply speed with divider
// reset, settle, then re-enable the derived clocks.
module clk_speed_ctrl
  import usb4_clk_pkg::*;
#(
  parameter logic [1:0]  RESET_SPEED    = SPEED_0,
  parameter int unsigned DRAIN_CYCLES   = 16,
  parameter int unsigned DRAIN_TIMEOUT  = 200,
  parameter int unsigned GATE_CYCLES    = 4,
  parameter int unsigned DIV_RST_CYCLES = 4,
  parameter int unsigned SETTLE_CYCLES  = 64,
  parameter int unsigned TW             = 8
) (
  input  logic       local_clk,
  input  logic       rst,
  input  logic [1:0] speed_req,
  input  logic       speed_req_vld,
  output logic       speed_req_rdy,
  input  logic       dp_idle,
  output logic [1:0] gen_speed,
  output logic       div_rst_n,
  output logic       clk_gate_en,
  output logic       speed_ack,
  output logic       speed_err,
  output logic       busy
);

  localparam logic [TW-1:0] DRAIN_LD  = TW'(DRAIN_CYCLES - 1);
  localparam logic [TW-1:0] TO_LD     = TW'(DRAIN_TIMEOUT - 1);
  localparam logic [TW-1:0] GATE_LD   = TW'(GATE_CYCLES - 1);
  localparam logic [TW-1:0] DIVRST_LD = TW'(DIV_RST_CYCLES - 1);
  localparam logic [TW-1:0] SETTLE_LD = TW'(SETTLE_CYCLES - 1);

  ctrl_state_t   state;
  logic          init;
  logic [1:0]    target;
  logic [TW-1:0] idle_cnt;
  logic [TW-1:0] to_cnt;
  logic          tmr_load;
  logic [TW-1:0] tmr_val;
  logic          tmr_zero;
  logic          drain_done;
  logic          drain_to;

  // Drain completion takes priority over a timeout landing on the same cycle.
  assign drain_done = dp_idle && (idle_cnt == DRAIN_LD);
  assign drain_to   = !drain_done && (to_cnt == TO_LD);

  // Timer is reloaded with the next state's length-1 on every timed-state entry.
  always_comb begin
    tmr_load = 1'b0;
    tmr_val  = '0;
    case (state)
      ST_DRAIN:  if (drain_done) begin tmr_load = 1'b1; tmr_val = GATE_LD;   end
      ST_GATE:   if (tmr_zero)   begin tmr_load = 1'b1; tmr_val = DIVRST_LD; end
      ST_APPLY:  if (tmr_zero)   begin tmr_load = 1'b1; tmr_val = SETTLE_LD; end
      ST_SETTLE: if (tmr_zero)   begin tmr_load = 1'b1; tmr_val = '0;        end
      default: ;
    endcase
  end

  clk_speed_timer #(
    .TW      (TW),
    .RST_VAL (DIVRST_LD)
  ) u_timer (
    .local_clk (local_clk),
    .rst       (rst),
    .load      (tmr_load),
    .load_val  (tmr_val),
    .zero      (tmr_zero)
  );

  // Sequencer FSM; outputs are set on entry to each state so they are registered.
  always_ff @(posedge local_clk or negedge rst) begin
    if (!rst) begin
      state         <= ST_APPLY;
      init          <= 1'b1;
      target        <= RESET_SPEED;
      gen_speed     <= RESET_SPEED;
      div_rst_n     <= 1'b0;
      clk_gate_en   <= 1'b0;
      speed_req_rdy <= 1'b0;
      speed_ack     <= 1'b0;
      speed_err     <= 1'b0;
      busy          <= 1'b1;
      idle_cnt      <= '0;
      to_cnt        <= '0;
    end else begin
      speed_ack <= 1'b0;
      speed_err <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (speed_req_vld && speed_req_rdy) begin
            if (speed_is_rsvd(speed_req)) begin
              speed_err <= 1'b1;
            end else if (speed_req == gen_speed) begin
              speed_ack <= 1'b1;
            end else begin
              target        <= speed_req;
              state         <= ST_DRAIN;
              speed_req_rdy <= 1'b0;
              busy          <= 1'b1;
              idle_cnt      <= '0;
              to_cnt        <= '0;
            end
          end
        end
        ST_DRAIN: begin
          if (drain_done) begin
            state       <= ST_GATE;
            clk_gate_en <= 1'b0;
          end else if (drain_to) begin
            state         <= ST_IDLE;
            speed_err     <= 1'b1;
            speed_req_rdy <= 1'b1;
            busy          <= 1'b0;
          end else begin
            if (!dp_idle) begin
              idle_cnt <= '0;
            end else if (idle_cnt != '1) begin
              idle_cnt <= idle_cnt + TW'(1);
            end
            if (to_cnt != '1) begin
              to_cnt <= to_cnt + TW'(1);
            end
          end
        end
        ST_GATE: begin
          if (tmr_zero) begin
            state     <= ST_APPLY;
            gen_speed <= target;
            div_rst_n <= 1'b0;
          end
        end
        ST_APPLY: begin
          if (tmr_zero) begin
            state     <= ST_SETTLE;
            div_rst_n <= 1'b1;
          end
        end
        ST_SETTLE: begin
          if (tmr_zero) begin
            state       <= ST_RELEASE;
            clk_gate_en <= 1'b1;
            speed_ack   <= !init;
          end
        end
        ST_RELEASE: begin
          state         <= ST_IDLE;
          init          <= 1'b0;
          speed_req_rdy <= 1'b1;
          busy          <= 1'b0;
        end
        default: state <= ST_APPLY;
      endcase
    end
  end

endmodule
